// File: rtl/seq_detect_sched.sv
// Round-robin time-shared serial pattern detector for NCH independent bit streams.
// Each stream keeps its own history and fill count; one compare per cycle.
module seq_detect_sched #(
    parameter int                 NCH     = 4,
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
    parameter int                 CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH-1:0]         in_bit,
    output logic [NCH-1:0]         in_ready,
    output logic                   match,
    output logic [$clog2(NCH)-1:0] match_ch,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int CH_W   = $clog2(NCH);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int HIST_W = PAT_LEN - 1;

    // Only the newest PAT_LEN-1 bits can ever take part in a future compare.
    logic [HIST_W-1:0] r_hist [NCH];
    logic [FILL_W-1:0] r_fill [NCH];
    logic [CH_W-1:0]   r_ptr;
    logic              r_match;
    logic [CH_W-1:0]   r_match_ch;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_any;
    logic [CH_W-1:0]   w_gnt;
    logic [CH_W-1:0]   w_ptr_nxt;
    logic              w_xfer;
    logic              w_hit;
    logic [FILL_W-1:0] w_fill_g;
    logic [PAT_LEN-1:0] w_shift;

    // Lowest offset from the pointer wins, so iterate downwards.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (in_valid[(int'(r_ptr) + k) % NCH]) begin
                w_gnt = CH_W'((int'(r_ptr) + k) % NCH);
                w_any = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == CH_W'(NCH - 1)) ? '0 : w_gnt + 1'b1;
    assign w_xfer    = w_any & ~clr;
    assign in_ready  = (w_xfer & rst_n)
                     ? ({{(NCH-1){1'b0}}, 1'b1} << w_gnt)
                     : '0;

    assign w_fill_g = r_fill[w_gnt];
    assign w_shift  = {r_hist[w_gnt], in_bit[w_gnt]};
    assign w_hit    = w_xfer
                   && (w_fill_g >= FILL_W'(PAT_LEN - 1))
                   && (w_shift == PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_match    <= 1'b0;
            r_match_ch <= '0;
            r_cnt      <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i] <= '0;
                r_fill[i] <= '0;
            end
        end else if (clr) begin
            r_ptr   <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i] <= '0;
                r_fill[i] <= '0;
            end
        end else begin
            r_match <= w_hit;
            if (w_hit) begin
                r_match_ch <= w_gnt;
                if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_xfer) begin
                r_ptr         <= w_ptr_nxt;
                r_hist[w_gnt] <= w_shift[HIST_W-1:0];
                if (w_fill_g != FILL_W'(PAT_LEN)) begin
                    r_fill[w_gnt] <= w_fill_g + 1'b1;
                end
            end
        end
    end

    assign match     = r_match;
    assign match_ch  = r_match_ch;
    assign match_cnt = r_cnt;

endmodule
